// File: rtl/sr_flag_bank.sv
// sr_flag_bank: a bank of WIDTH independent set/reset flags.
//
// Each channel takes a set request (s) and a reset request (r). Both pass
// through an optional SYNC_STAGES-deep synchronizer and, with EDGE=1, a
// rising-edge detector. The flag register then follows SR semantics, and
// MODE decides what happens when set and reset coincide. A synchronous clr
// wipes every flag and conflict bit. The synchronizer and edge registers
// keep running while clr is high.
//
// Parameters
//   WIDTH        number of channels (1..32)
//   MODE         set+reset conflict: 0 set wins, 1 reset wins, 2 toggle, 3 hold
//   SYNC_STAGES  synchronizer depth (0..3), 0 = inputs used directly
//   EDGE         0 level-triggered, 1 rising-edge-triggered
//
// Ports
//   clk       clock, all state changes on rising edge
//   rst_n     asynchronous active-low reset
//   s, r      per-channel set / reset requests
//   clr       synchronous clear of q and conflict
//   q         registered flag state
//   q_bar     ~q
//   conflict  one-cycle pulse where effective set and reset coincided
//   any_set   |q
//   count     number of ones in q
module sr_flag_bank #(
  parameter int WIDTH       = 8,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             s,
  input  logic [WIDTH-1:0]             r,
  input  logic                         clr,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             q_bar,
  output logic [WIDTH-1:0]             conflict,
  output logic                         any_set,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] s_sync;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] se;
  logic [WIDTH-1:0] re;

  // Next flag state for every channel. Bits with exactly one request, or
  // with none, follow plain SR behaviour. Bits with both requests follow MODE.
  function automatic logic [WIDTH-1:0] next_q(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] set_e,
                                              input logic [WIDTH-1:0] rst_e);
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] plain;
    logic [WIDTH-1:0] res;
    both  = set_e & rst_e;
    plain = ((cur | set_e) & ~rst_e) & ~both;
    case (MODE)
      0:       res = plain | both;
      1:       res = plain;
      2:       res = plain | (~cur & both);
      default: res = plain | (cur & both);
    endcase
    return res;
  endfunction

  // Synchronizer stage: SYNC_STAGES flops per bit. Reset clears every stage,
  // so requests still in flight are dropped.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_sync = s;
    assign r_sync = r;
  end else begin : g_sync
    logic [WIDTH-1:0] s_pipe [SYNC_STAGES];
    logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          s_pipe[i] <= '0;
          r_pipe[i] <= '0;
        end
      end else begin
        s_pipe[0] <= s;
        r_pipe[0] <= r;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          s_pipe[i] <= s_pipe[i-1];
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign s_sync = s_pipe[SYNC_STAGES-1];
    assign r_sync = r_pipe[SYNC_STAGES-1];
  end

  // Edge stage: the previous-value registers reset to 0. After reset, an
  // edge is seen only when the synchronized input really is 1.
  if (EDGE == 1) begin : g_edge
    logic [WIDTH-1:0] s_prev;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_prev <= '0;
        r_prev <= '0;
      end else begin
        s_prev <= s_sync;
        r_prev <= r_sync;
      end
    end

    assign se = s_sync & ~s_prev;
    assign re = r_sync & ~r_prev;
  end else begin : g_level
    assign se = s_sync;
    assign re = r_sync;
  end

  // Flag stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      conflict <= '0;
    end else if (clr) begin
      q        <= '0;
      conflict <= '0;
    end else begin
      q        <= next_q(q, se, re);
      conflict <= se & re;
    end
  end

  assign q_bar   = ~q;
  assign any_set = |q;

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(q[i]);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Testbench for sr_flag_bank. Five instances share one stimulus stream:
//   u0 MODE0 SYNC2 level, u1 MODE1 SYNC2 level, u2 MODE2 SYNC0 level,
//   u3 MODE3 SYNC2 level, u4 MODE0 SYNC2 edge.
// Expected values are queued with a due cycle when stimulus is driven and
// compared when that cycle's rising edge has passed.
module tb_sr_flag_bank;

  localparam int N     = 5;
  localparam int K_Q   = 0;
  localparam int K_QB  = 1;
  localparam int K_CF  = 2;
  localparam int K_CNT = 3;
  localparam int K_ANY = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s;
  logic [7:0] r;
  logic       clr;

  logic [7:0] q_o   [N];
  logic [7:0] qb_o  [N];
  logic [7:0] cf_o  [N];
  logic       any_o [N];
  logic [3:0] cnt_o [N];

  always #5 clk = ~clk;

  sr_flag_bank #(.WIDTH(8), .MODE(0), .SYNC_STAGES(2), .EDGE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr(clr),
    .q(q_o[0]), .q_bar(qb_o[0]), .conflict(cf_o[0]), .any_set(any_o[0]), .count(cnt_o[0]));
  sr_flag_bank #(.WIDTH(8), .MODE(1), .SYNC_STAGES(2), .EDGE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr(clr),
    .q(q_o[1]), .q_bar(qb_o[1]), .conflict(cf_o[1]), .any_set(any_o[1]), .count(cnt_o[1]));
  sr_flag_bank #(.WIDTH(8), .MODE(2), .SYNC_STAGES(0), .EDGE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr(clr),
    .q(q_o[2]), .q_bar(qb_o[2]), .conflict(cf_o[2]), .any_set(any_o[2]), .count(cnt_o[2]));
  sr_flag_bank #(.WIDTH(8), .MODE(3), .SYNC_STAGES(2), .EDGE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr(clr),
    .q(q_o[3]), .q_bar(qb_o[3]), .conflict(cf_o[3]), .any_set(any_o[3]), .count(cnt_o[3]));
  sr_flag_bank #(.WIDTH(8), .MODE(0), .SYNC_STAGES(2), .EDGE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr(clr),
    .q(q_o[4]), .q_bar(qb_o[4]), .conflict(cf_o[4]), .any_set(any_o[4]), .count(cnt_o[4]));

  typedef struct {
    int         due;
    int         inst;
    int         kind;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] observe(input int inst, input int kind);
    logic [7:0] v;
    case (kind)
      K_Q:     v = q_o[inst];
      K_QB:    v = qb_o[inst];
      K_CF:    v = cf_o[inst];
      K_CNT:   v = {4'b0000, cnt_o[inst]};
      default: v = {7'b0000000, any_o[inst]};
    endcase
    return v;
  endfunction

  task automatic push_exp(input int inst, input int kind, input int dly,
                          input logic [7:0] v, input string tag);
    exp_t e;
    e.due  = cyc + dly;
    e.inst = inst;
    e.kind = kind;
    e.exp  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Advance one rising edge, then compare everything due at this cycle.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].due <= cyc) begin
        check($sformatf("%s.u%0d@%0d", sb[i].tag, sb[i].inst, cyc),
              observe(sb[i].inst, sb[i].kind), sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("sb_drain", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    drain();
    s = '0; r = '0; clr = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Independent per-bit reference for one flag update.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] se,
                                            input logic [7:0] re, input int mode);
    logic [7:0] n;
    for (int b = 0; b < 8; b++) begin
      case ({se[b], re[b]})
        2'b00: n[b] = cur[b];
        2'b10: n[b] = 1'b1;
        2'b01: n[b] = 1'b0;
        default: begin
          case (mode)
            0:       n[b] = 1'b1;
            1:       n[b] = 1'b0;
            2:       n[b] = ~cur[b];
            default: n[b] = cur[b];
          endcase
        end
      endcase
    end
    return n;
  endfunction

  initial begin
    logic [7:0] qm [N];
    logic [7:0] sl;
    logic [7:0] rl;
    logic [7:0] se;
    logic [7:0] re;
    int         modes [N];
    modes = '{0, 1, 2, 3, 0};

    // Asynchronous reset, checked before any clock edge.
    s = '0; r = '0; clr = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_q.u%0d", i),   q_o[i],  8'h00);
      check($sformatf("rst_qb.u%0d", i),  qb_o[i], 8'hFF);
      check($sformatf("rst_cf.u%0d", i),  cf_o[i], 8'h00);
      check($sformatf("rst_cnt.u%0d", i), {4'b0, cnt_o[i]}, 8'h00);
      check($sformatf("rst_any.u%0d", i), {7'b0, any_o[i]}, 8'h00);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single-cycle set on channel 0: latency SYNC_STAGES+1.
    s = 8'h01;
    push_exp(0, K_Q,   2, 8'h00, "a_early");
    push_exp(0, K_Q,   3, 8'h01, "a_q");
    push_exp(0, K_QB,  3, 8'hFE, "a_qb");
    push_exp(0, K_CNT, 3, 8'h01, "a_cnt");
    push_exp(0, K_ANY, 3, 8'h01, "a_any");
    push_exp(0, K_Q,   4, 8'h01, "a_hold");
    push_exp(2, K_Q,   1, 8'h01, "a_q_s0");
    tick();
    s = 8'h00;

    // Full conflict, resolved per MODE.
    do_reset();
    s = 8'h0F;
    push_exp(0, K_Q, 3, 8'h0F, "b_pre");
    push_exp(3, K_Q, 3, 8'h0F, "b_pre");
    push_exp(2, K_Q, 1, 8'h0F, "b_pre");
    tick();
    s = 8'hFF; r = 8'hFF;
    push_exp(0, K_Q,   3, 8'hFF, "b_q");
    push_exp(0, K_CF,  3, 8'hFF, "b_cf");
    push_exp(0, K_CNT, 3, 8'h08, "b_cnt");
    push_exp(0, K_ANY, 3, 8'h01, "b_any");
    push_exp(0, K_CF,  4, 8'h00, "b_cf_end");
    push_exp(0, K_Q,   4, 8'hFF, "b_q_hold");
    push_exp(1, K_Q,   3, 8'h00, "b_q");
    push_exp(1, K_CF,  3, 8'hFF, "b_cf");
    push_exp(3, K_Q,   3, 8'h0F, "b_q");
    push_exp(3, K_CF,  3, 8'hFF, "b_cf");
    push_exp(3, K_CF,  4, 8'h00, "b_cf_end");
    push_exp(2, K_Q,   1, 8'hF0, "b_tog");
    tick();
    s = 8'h00; r = 8'h00;

    // Toggle mode held three cycles, no synchronizer.
    do_reset();
    s = 8'h0F;
    push_exp(2, K_Q, 1, 8'h0F, "c_pre");
    tick();
    s = 8'hFF; r = 8'hFF;
    push_exp(2, K_Q,  1, 8'hF0, "c_t1");
    push_exp(2, K_CF, 1, 8'hFF, "c_cf");
    push_exp(2, K_Q,  2, 8'h0F, "c_t2");
    push_exp(2, K_Q,  3, 8'hF0, "c_t3");
    push_exp(2, K_Q,  4, 8'hF0, "c_hold");
    tick(); tick(); tick();
    s = 8'h00; r = 8'h00;

    // Edge mode: s[3] held, r[3] pulsed, then s[3] re-rises.
    do_reset();
    s = 8'h08;
    push_exp(4, K_Q, 3, 8'h08, "e_set");
    push_exp(4, K_Q, 7, 8'h08, "e_hold");
    repeat (5) tick();
    r = 8'h08;
    push_exp(4, K_Q, 3, 8'h00, "e_clr");
    tick();
    r = 8'h00;
    push_exp(4, K_Q, 4, 8'h00, "e_no_reset");
    repeat (4) tick();
    s = 8'h00;
    push_exp(4, K_Q, 3, 8'h00, "e_low");
    tick(); tick();
    s = 8'h08;
    push_exp(4, K_Q, 3, 8'h08, "e_reset");
    tick();

    // Clear overrides coincident set and reset.
    do_reset();
    s = 8'hAA;
    push_exp(0, K_Q, 3, 8'hAA, "f_pre");
    push_exp(2, K_Q, 1, 8'hAA, "f_pre");
    repeat (3) tick();
    s = 8'hFF; r = 8'hFF; clr = 1'b1;
    push_exp(0, K_Q,   1, 8'h00, "f_clr_q");
    push_exp(0, K_CF,  1, 8'h00, "f_clr_cf");
    push_exp(0, K_CNT, 1, 8'h00, "f_clr_cnt");
    push_exp(2, K_Q,   1, 8'h00, "f_clr_q");
    push_exp(2, K_CF,  1, 8'h00, "f_clr_cf");
    push_exp(0, K_Q,   3, 8'h00, "f_ovr_q");
    push_exp(0, K_CF,  3, 8'h00, "f_ovr_cf");
    tick(); tick(); tick();
    clr = 1'b0; s = 8'h00; r = 8'h00;
    push_exp(0, K_Q,  1, 8'hFF, "f_post_q");
    push_exp(0, K_CF, 1, 8'hFF, "f_post_cf");
    tick();

    // Reset between edges with a request inside the synchronizer.
    do_reset();
    s = 8'h0F;
    push_exp(0, K_Q, 3, 8'h0F, "g_pre");
    repeat (3) tick();
    s = 8'hFF;
    tick();
    s = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    check("g_rst_q",   q_o[0],  8'h00);
    check("g_rst_qb",  qb_o[0], 8'hFF);
    check("g_rst_cnt", {4'b0, cnt_o[0]}, 8'h00);
    check("g_rst_any", {7'b0, any_o[0]}, 8'h00);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) push_exp(0, K_Q, k, 8'h00, "g_stale");
    repeat (5) tick();

    // Random traffic against the reference model on every instance.
    do_reset();
    for (int i = 0; i < N; i++) qm[i] = '0;
    sl = '0; rl = '0;
    for (int n = 0; n < 300; n++) begin
      s = 8'($urandom);
      r = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        if (i == 4) begin
          se = s & ~sl;
          re = r & ~rl;
        end else begin
          se = s;
          re = r;
        end
        qm[i] = model_next(qm[i], se, re, modes[i]);
        push_exp(i, K_Q,  (i == 2) ? 1 : 3, qm[i],   "rnd_q");
        push_exp(i, K_CF, (i == 2) ? 1 : 3, se & re, "rnd_cf");
      end
      push_exp(0, K_CNT, 3, 8'($countones(qm[0])), "rnd_cnt");
      push_exp(0, K_QB,  3, ~qm[0],                "rnd_qb");
      sl = s;
      rl = r;
      tick();
    end
    s = 8'h00; r = 8'h00;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
